// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, a held data byte and sticky error flags.
// Revision: 1.0
`default_nettype none

module uart_rx #(
  parameter int unsigned DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      state, state_n;
  logic        rx_m, rx_s;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  sh, sh_n;
  logic [7:0]  data_n;
  logic        valid_n, frame_err_n, overrun_n;
  logic        tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
    end
  end

  assign tick = (cnt == 16'd0);
  assign busy = (state != S_IDLE);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt - 16'd1;
    idx_n       = idx;
    sh_n        = sh;
    data_n      = data;
    // A read clears the flags; a same-edge delivery or framing error below overrides it.
    valid_n     = valid & ~rd;
    frame_err_n = frame_err & ~rd;
    overrun_n   = overrun & ~rd;

    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_n   = HALF_M1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_s) begin
            cnt_n   = FULL_M1;
            idx_n   = 3'd0;
            state_n = S_DATA;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sh_n  = {rx_s, sh[7:1]};
          cnt_n = FULL_M1;
          if (idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s) begin
            data_n  = sh;
            valid_n = 1'b1;
            if (valid && !rd) begin
              overrun_n = 1'b1;
            end
            state_n = S_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Stay here until the line returns high so a held-low line reports only once.
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a byte-level model of the receiver.
// Revision: 1.0
`default_nettype none

module tb_uart_rx;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rd  = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_ov    = 1'b0;
  bit         m_known = 1'b1;

  uart_rx #(.DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd        (rd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_rd();
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
  endtask

  // Byte-level view: a good frame replaces the byte (overrun if unread), a bad one only flags.
  task automatic model_deliver(input logic [7:0] b, input bit stop);
    if (stop) begin
      if (m_valid) m_ov = 1'b1;
      m_data  = b;
      m_valid = 1'b1;
      m_known = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    if (m_known) check($sformatf("%s.data", tag), 32'(data), 32'(m_data));
    check($sformatf("%s.valid", tag), 32'(valid), 32'(m_valid));
    check($sformatf("%s.frame_err", tag), 32'(frame_err), 32'(m_fe));
    check($sformatf("%s.overrun", tag), 32'(overrun), 32'(m_ov));
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    rd = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
    model_rd();
  endtask

  // Drives one 8N1 frame; optionally pulses rd on its first cycle. rise_at is the first
  // cycle at which valid (good stop) or frame_err (bad stop) is observed high.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit do_rd,
                            output int rise_at, output bit busy_seen);
    logic [9:0] bits;
    bits      = {stop, b, 1'b0};
    rise_at   = -1;
    busy_seen = 1'b0;
    for (int c = 0; c < 10 * DIV; c++) begin
      rx = bits[c / DIV];
      rd = do_rd && (c == 0);
      @(posedge clk);
      #1;
      if (busy) busy_seen = 1'b1;
      if (rise_at < 0 && (stop ? valid : frame_err)) rise_at = c;
    end
    rd = 1'b0;
    if (do_rd) model_rd();
    model_deliver(b, stop);
  endtask

  initial begin
    int  rise;
    bit  bsy;
    bit  seen;
    bit  prev_bad;
    logic [9:0] bits;

    repeat (3) @(posedge clk);
    #1;
    check("reset.data", 32'(data), 32'h0);
    check("reset.valid", 32'(valid), 32'h0);
    check("reset.frame_err", 32'(frame_err), 32'h0);
    check("reset.overrun", 32'(overrun), 32'h0);
    check("reset.busy", 32'(busy), 32'h0);
    rst = 1'b0;
    idle(4);

    // Single byte with exact delivery cycle
    send_frame(8'h55, 1'b1, 1'b0, rise, bsy);
    check_model("single");
    check("single.rise_cycle", 32'(rise), 32'(10 * DIV - 2));
    check("single.busy_seen", 32'(bsy), 32'h1);
    pulse_rd();
    check_model("single_rd");
    idle(DIV);

    // Back-to-back, rd at the start of the second frame
    send_frame(8'hA3, 1'b1, 1'b0, rise, bsy);
    check_model("b2b_first");
    send_frame(8'h0F, 1'b1, 1'b1, rise, bsy);
    check_model("b2b_second");
    pulse_rd();
    idle(DIV);

    // Overrun
    send_frame(8'h12, 1'b1, 1'b0, rise, bsy);
    send_frame(8'h34, 1'b1, 1'b0, rise, bsy);
    check_model("overrun");
    pulse_rd();
    check_model("overrun_rd");
    idle(DIV);

    // Glitch shorter than half a bit
    seen = 1'b0;
    rx = 1'b0;
    repeat (DIV / 2 - 2) @(posedge clk);
    #1;
    rx = 1'b1;
    for (int c = 0; c < 2 * DIV; c++) begin
      @(posedge clk);
      #1;
      if (busy) seen = 1'b1;
    end
    check("glitch.busy_seen", 32'(seen), 32'h1);
    check("glitch.busy_end", 32'(busy), 32'h0);
    check_model("glitch");

    // Framing error then long break
    send_frame(8'hFF, 1'b0, 1'b0, rise, bsy);
    check_model("frame");
    check("frame.rise_cycle", 32'(rise), 32'(10 * DIV - 2));
    seen = 1'b0;
    for (int c = 0; c < 30 * DIV; c++) begin
      rx = 1'b0;
      rd = (c == 0);
      @(posedge clk);
      #1;
      if (frame_err || valid) seen = 1'b1;
    end
    rd = 1'b0;
    model_rd();
    check("break.no_new_flags", 32'(seen), 32'h0);
    check("break.busy", 32'(busy), 32'h1);
    idle(DIV);
    check("break.released_busy", 32'(busy), 32'h0);
    send_frame(8'h5A, 1'b1, 1'b0, rise, bsy);
    check_model("after_break");
    pulse_rd();
    idle(DIV);

    // Reset during data bit 4 of 0xC3
    bits = {1'b1, 8'hC3, 1'b0};
    for (int c = 0; c < 10 * DIV; c++) begin
      rx  = bits[c / DIV];
      rst = (c == 5 * DIV + DIV / 2);
      @(posedge clk);
      #1;
      if (c == 5 * DIV + DIV / 2) begin
        check("midrst.data", 32'(data), 32'h0);
        check("midrst.valid", 32'(valid), 32'h0);
        check("midrst.frame_err", 32'(frame_err), 32'h0);
        check("midrst.overrun", 32'(overrun), 32'h0);
        check("midrst.busy", 32'(busy), 32'h0);
      end
    end
    rst = 1'b0;
    m_known = 1'b0;
    idle(12 * DIV);
    pulse_rd();
    send_frame(8'h81, 1'b1, 1'b0, rise, bsy);
    check_model("after_rst");
    pulse_rd();
    idle(DIV);

    // Randomized stream, stand-in for a matching transmitter looped back
    prev_bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      bit         stop;
      bit         do_rd;
      int         gap;
      b     = 8'($urandom);
      stop  = ($urandom_range(0, 4) != 0);
      do_rd = ($urandom_range(0, 1) == 1);
      gap   = prev_bad ? int'($urandom_range(2, DIV)) : int'($urandom_range(0, DIV));
      if (gap > 0) idle(gap);
      send_frame(b, stop, do_rd, rise, bsy);
      check_model($sformatf("rand%0d", i));
      prev_bad = !stop;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial 8N1 UART receiver, the counterpart of the machine's `uart_tx` output. It lets the bench loop the transmitter back, and gives the CPU a console input path. It synchronizes the asynchronous `rx` line, detects start bits, samples each bit at mid-period, and validates the stop bit. The received byte is held in a register with a valid flag, plus sticky framing-error and overrun flags. All of these are cleared by a one-cycle read strobe from the bus side.

## Interface
- `DIV`, default 104: clock cycles per bit (12 MHz / 115200). Legal range is ≥ 4 and ≤ 65535. `DIV/2` is integer division.
- `clk` input, 1 bit: the single clock; all logic is on its rising edge.
- `rst` input, 1 bit: synchronous reset, active-high.
- `rx` input, 1 bit: serial line; asynchronous; idles high.
- `rd` input, 1 bit: read/acknowledge strobe, one cycle wide; clears `valid`, `frame_err` and `overrun`.
- `data` output, 8 bits: last successfully received byte.
- `valid` output, 1 bit: `data` holds an unread byte.
- `frame_err` output, 1 bit: sticky; a stop bit was sampled low.
- `overrun` output, 1 bit: sticky; a byte was delivered while `valid` was still set.
- `busy` output, 1 bit: high in every state other than IDLE.

## Operation
- **Synchronizer:** two flops, `rx` → `rx_s`, both reset to 1. All decisions use `rx_s` only.
- **Counters:**
  - Bit-timer `cnt`: 16 bits, decrements every cycle; an action fires when `cnt == 0`.
  - Bit index `idx`: 3 bits.
  - Shift register `sh`: 8 bits, LSB first. Each sample shifts `rx_s` into `sh[7]`.
- **State IDLE:** if `rx_s == 0`, load `cnt = DIV/2 − 1` and go to START.
- **State START** (at `cnt == 0`):
  - `rx_s == 0`: load `cnt = DIV − 1`, `idx = 0`, go to DATA.
  - Otherwise it was a glitch: go to IDLE and change no flags.
- **State DATA** (at `cnt == 0`): shift in `rx_s` and load `cnt = DIV − 1`.
  - If `idx == 7`, go to STOP.
  - Otherwise increment `idx`.
- **State STOP** (at `cnt == 0`):
  - `rx_s == 1`: `data <= sh`, `valid <= 1`. If `valid` was already 1 and `rd` is low this cycle, also set `overrun <= 1`. The old byte is overwritten. Go to IDLE.
  - `rx_s == 0`: set `frame_err <= 1`. `data` and `valid` are unchanged. Go to BREAK.
- **State BREAK:** wait for `rx_s == 1`, then go to IDLE. A held-low line therefore produces exactly one `frame_err` and no spurious frames.
- **rd:** clears `valid`, `frame_err` and `overrun` in the same edge.
  - `rd` coinciding with delivery: the new byte wins. `valid` stays 1, `data` takes the new byte, `overrun` is not set.
  - `rd` coinciding with a framing error: `frame_err` ends at 1.
- **Reset values:** `data = 0`, `valid = 0`, `frame_err = 0`, `overrun = 0`, `busy = 0`. State is IDLE; `cnt`, `idx` and `sh` are 0; sync flops are 1.
- **Reset mid-frame:** the partial byte is discarded. After release the receiver is in IDLE. If `rx` is low at that point, because a frame is still in progress on the line, that low is treated as a start bit. The bench must tolerate any resulting garbage or `frame_err`.

## Timing
- `rx_s` lags `rx` by 2 cycles.
- Let cycle k be the first IDLE cycle with `rx_s == 0`.
  - Start-bit check happens at k + DIV/2.
  - Data bit n is sampled at k + DIV/2 + (n+1)·DIV.
  - Stop bit is sampled at k + DIV/2 + 9·DIV.
  - `valid` (or `frame_err`) is visible the following cycle.
- The receiver is back in IDLE one cycle after the stop sample, about DIV/2 before the nominal end of the stop bit. Back-to-back frames with no idle gap are therefore received.
- `rd` takes effect on the next edge; flags read 0 the cycle after `rd`.
- Sampling point is mid-bit, giving a tolerance of about ±4% cumulative baud mismatch over 10 bits.

## Test plan
- **Single byte:** DIV=8; drive 0x55 as 8N1 (LSB first) → `data = 0x55`, `valid = 1` at the cycle given above, `frame_err = 0`, `overrun = 0`; pulse `rd` → `valid = 0`.
- **Back-to-back:** DIV=8; send 0xA3 then 0x0F with no idle gap; pulse `rd` after the first byte → read 0xA3 then 0x0F, `overrun = 0`.
- **Overrun:** send 0x12 then 0x34 without `rd` → `data = 0x34`, `valid = 1`, `overrun = 1`; one `rd` clears both flags.
- **Glitch:** pull `rx` low for DIV/2 − 2 cycles → receiver returns to IDLE, `busy` drops, no flag changes.
- **Framing/break:** send 0xFF with the stop bit low, then hold `rx` low for 30·DIV cycles and release → exactly one `frame_err = 1`, `valid = 0`; a following 0x5A is received correctly.
- **Reset mid-frame:** assert `rst` during DATA bit 4 of 0xC3 → all outputs go to reset values the next cycle; after release, with `rx` driven high for ≥ 2 cycles, the next 0x81 is received correctly; the bench waits out the interrupted frame first.
- **Loopback:** connect the machine's `uart_tx` to `rx` with a matching DIV → received bytes equal the transmitted bytes.
